// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if
//   Byte-side bundle of the UART receiver: received byte with valid/ready
//   pop handshake plus the two single-cycle error pulses.
//   rdata     [7:0] received byte, valid while rvalid=1
//   rvalid          byte available
//   rready          consumer pops when rvalid&rready at posedge
//   frame_err       1-cycle pulse, stop bit sampled low
//   overrun         1-cycle pulse, completed byte dropped (storage full)
//   Modports: master = receiver side, slave = consumer side.
interface uart_rx_core_if;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic       frame_err;
    logic       overrun;

    modport master (output rdata, output rvalid, output frame_err, output overrun,
                    input  rready);
    modport slave  (input  rdata, input  rvalid, input  frame_err, input  overrun,
                    output rready);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   8N1 UART receiver. Synchronises the serial pin, detects the start bit,
//   samples each bit at its middle, checks the stop bit and hands received
//   bytes to the consumer over a valid/ready pop handshake.
//   Ports:
//     clk      system clock
//     reset    synchronous, active-high
//     uart_rx  asynchronous serial line, idle high
//     bus      uart_rx_core_if.master (rdata/rvalid/rready/frame_err/overrun)
//   Parameters:
//     WAIT     clocks per bit (>= 4)
//     DEPTH    FIFO entries (power of 2, >= 2), used only with the macro below
//   Configuration macro: UART_RX_FIFO_EN
//     defined   -> DEPTH-entry circular FIFO between receiver and consumer
//     undefined -> single holding register
module uart_rx_core #(
    parameter int WAIT  = 868,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             uart_rx,
    uart_rx_core_if.master   bus
);
    localparam int CW = $clog2(WAIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(WAIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state, state_nxt;
    logic [1:0]      sync;
    logic            rx_s;
    logic [CW-1:0]   clk_cnt, clk_cnt_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            push;
    logic            ferr;
    logic            frame_err_q;
    logic            overrun_q;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], uart_rx};
    end
    assign rx_s = sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            clk_cnt     <= clk_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            frame_err_q <= ferr;
        end
    end

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        push        = 1'b0;
        ferr        = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                // Half a bit in: still low means a real start bit, else a glitch.
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = {rx_s, shift[7:1]};  // LSB arrives first
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    if (rx_s) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr      = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before a new start is seen.
                clk_cnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, wr_en;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && bus.rready;
    // A pop in the same cycle frees the slot the new byte lands in.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            overrun_q <= push && full && !pop;
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= shift;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign bus.rdata  = mem[rd_ptr[AW-1:0]];
    assign bus.rvalid = !empty;
`else
    logic [7:0] hold;
    logic       hold_vld;
    logic       pop;

    assign pop = hold_vld && bus.rready;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold      <= '0;
            hold_vld  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && hold_vld && !pop;
            if (push && (!hold_vld || pop)) begin
                hold     <= shift;
                hold_vld <= 1'b1;
            end else if (pop) begin
                hold_vld <= 1'b0;
            end
        end
    end

    assign bus.rdata  = hold;
    assign bus.rvalid = hold_vld;
`endif

    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
//   Self-checking bench for uart_rx_core at WAIT=8. Expected bytes are queued
//   when a frame is sent and compared by a negedge monitor on every pop;
//   error pulses are counted by the same monitor and checked per scenario.
//   Build with UART_RX_FIFO_EN defined to exercise the FIFO variant.
module tb_uart_rx_core;
    localparam int WAIT  = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 2 + WAIT / 2 + 9 * WAIT + 1;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;

    uart_rx_core_if bus ();

    uart_rx_core #(.WAIT(WAIT), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pop_cnt = 0;
    int rise_cyc = -1;
    int t_start = 0;
    logic rv_q = 1'b0;
    logic [7:0] exp_v;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: a pop happens at the next posedge whenever
    // rvalid&rready holds mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            rv_q = 1'b0;
        end else begin
            if (bus.rvalid && !rv_q) rise_cyc = cyc;
            rv_q = bus.rvalid;
            if (bus.frame_err) fe_cnt++;
            if (bus.overrun) ov_cnt++;
            if (bus.rvalid && bus.rready) begin
                pop_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected: got rdata=%h, required no byte", bus.rdata);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (bus.rdata !== exp_v) begin
                        bad++;
                        $display("FAIL pop_data: got rdata=%h, required %h", bus.rdata, exp_v);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame. rst_at >= 0 pulses reset at that bit-cycle index
    // and abandons the frame with the line returned high.
    task automatic send(input logic [7:0] d, input logic stop_b, input int rst_at);
        logic [9:0] fr;
        fr = {stop_b, d, 1'b0};
        for (int i = 0; i < 10 * WAIT; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) t_start = cyc;
            if (rst_at >= 0 && i == rst_at + 1) begin
                reset   = 1'b0;
                uart_rx = 1'b1;
                return;
            end
            if (rst_at >= 0 && i == rst_at) reset = 1'b1;
            uart_rx = fr[i / WAIT];
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rready = 1'b0;
        uart_rx = 1'b1;
        idle(4);
        total++;
        if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b, required 0", bus.rvalid); end
        total++;
        if (bus.rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h, required 00", bus.rdata); end
        total++;
        if ({bus.frame_err, bus.overrun} !== 2'b00) begin
            bad++; $display("FAIL reset_flags: got fe/ov=%b, required 00", {bus.frame_err, bus.overrun});
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        bus.rready = 1'b1;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, -1);
        idle(WAIT);
        total++;
        if (rise_cyc - t_start != LAT) begin
            bad++; $display("FAIL basic_latency: got %0d, required %0d", rise_cyc - t_start, LAT);
        end
        drain();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL basic_drain: got %0d left, required 0", exp_q.size()); end
        total++;
        if (pop_cnt != 1) begin bad++; $display("FAIL basic_pops: got %0d, required 1", pop_cnt); end
    endtask

    task automatic test_glitch();
        int p0, f0;
        p0 = pop_cnt;
        f0 = fe_cnt;
        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(3 * WAIT);
        total++;
        if (pop_cnt != p0 || bus.rvalid !== 1'b0) begin
            bad++; $display("FAIL glitch_rvalid: got pops=%0d rvalid=%b, required pops=%0d rvalid=0", pop_cnt, bus.rvalid, p0);
        end
        total++;
        if (fe_cnt != f0) begin bad++; $display("FAIL glitch_ferr: got %0d, required %0d", fe_cnt, f0); end
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, -1);
        drain();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL glitch_next: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_frame_err();
        int p0, f0, o0;
        p0 = pop_cnt;
        f0 = fe_cnt;
        o0 = ov_cnt;
        send(8'h3C, 1'b0, -1);
        idle(20 * WAIT);
        total++;
        if (fe_cnt != f0 + 1) begin bad++; $display("FAIL ferr_count: got %0d, required %0d", fe_cnt - f0, 1); end
        total++;
        if (pop_cnt != p0 || ov_cnt != o0) begin
            bad++; $display("FAIL ferr_side: got pops=%0d ov=%0d, required 0 0", pop_cnt - p0, ov_cnt - o0);
        end
        uart_rx = 1'b1;
        idle(2 * WAIT);
        exp_q.push_back(8'h01);
        send(8'h01, 1'b1, -1);
        drain();
        total++;
        if (exp_q.size() != 0 || fe_cnt != f0 + 1) begin
            bad++; $display("FAIL ferr_recover: got left=%0d fe=%0d, required 0 1", exp_q.size(), fe_cnt - f0);
        end
    endtask

    task automatic test_overrun();
        int o0;
        logic [7:0] b;
        o0 = ov_cnt;
        bus.rready = 1'b0;
        for (int k = 0; k <= CAP; k++) begin
            b = 8'((k + 1) * 17);
            if (k < CAP) exp_q.push_back(b);
            send(b, 1'b1, -1);
            idle(3);
            total++;
            if (ov_cnt - o0 != ((k >= CAP) ? 1 : 0)) begin
                bad++; $display("FAIL overrun_count byte%0d: got %0d, required %0d", k, ov_cnt - o0, (k >= CAP) ? 1 : 0);
            end
        end
        total++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 8'h11) begin
            bad++; $display("FAIL overrun_hold: got rvalid=%b rdata=%h, required 1 11", bus.rvalid, bus.rdata);
        end
        bus.rready = 1'b1;
        drain();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL overrun_drain: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int o0;
        o0 = ov_cnt;
        bus.rready = 1'b0;
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1, -1);
        idle(4);
        exp_q.push_back(8'h66);
        fork
            send(8'h66, 1'b1, -1);
            begin
                repeat (LAT) @(posedge clk);
                #1 bus.rready = 1'b1;
                @(posedge clk);
                #1 bus.rready = 1'b0;
            end
        join
        total++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 8'h66) begin
            bad++; $display("FAIL b2b_data: got rvalid=%b rdata=%h, required 1 66", bus.rvalid, bus.rdata);
        end
        idle(2);
        total++;
        if (ov_cnt != o0) begin bad++; $display("FAIL b2b_overrun: got %0d, required 0", ov_cnt - o0); end
        bus.rready = 1'b1;
        drain();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int p0;
        bus.rready = 1'b0;
        send(8'h99, 1'b1, -1);
        idle(4);
        // Bit-cycle 43 lies inside data bit 4 of the frame.
        send(8'h77, 1'b1, 5 * WAIT + 3);
        total++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 8'h00) begin
            bad++; $display("FAIL midreset_clear: got rvalid=%b rdata=%h, required 0 00", bus.rvalid, bus.rdata);
        end
        idle(2 * WAIT);
        p0 = pop_cnt;
        bus.rready = 1'b1;
        exp_q.push_back(8'h88);
        send(8'h88, 1'b1, -1);
        drain();
        idle(2);
        total++;
        if (exp_q.size() != 0 || pop_cnt != p0 + 1) begin
            bad++; $display("FAIL midreset_next: got left=%0d pops=%0d, required 0 1", exp_q.size(), pop_cnt - p0);
        end
    endtask

    initial begin
        bus.rready = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
